alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one combinational ALU, IDLE/EXEC/RESP FSM
// Optional macro ALUARB_RR_EN: round-robin grant; undefined gives fixed priority to requester 0.
`ifndef ALUOP_SIZE
`define ALUOP_SIZE 4
`endif

module alu_arbiter (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [31:0]            req0_operand1,
    input  logic [31:0]            req0_operand2,
    input  logic [`ALUOP_SIZE-1:0] req0_operation,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [31:0]            req1_operand1,
    input  logic [31:0]            req1_operand2,
    input  logic [`ALUOP_SIZE-1:0] req1_operation,
    output logic [31:0]            alu_operand1,
    output logic [31:0]            alu_operand2,
    output logic [`ALUOP_SIZE-1:0] alu_operation,
    input  logic [31:0]            alu_result,
    output logic                   rsp0_valid,
    input  logic                   rsp0_ready,
    output logic                   rsp1_valid,
    input  logic                   rsp1_ready,
    output logic [31:0]            rsp_result,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [31:0]              op1_q;
    logic [31:0]              op2_q;
    logic [`ALUOP_SIZE-1:0]   opc_q;
    logic                     owner;
    logic [31:0]              result_q;
    logic                     grant;
    logic                     transfer;
    logic                     rsp_fire;

`ifdef ALUARB_RR_EN
    logic ptr;

    // With both requesters valid the pointer decides; a lone requester always wins.
    always_comb begin
        grant = (req0_valid && req1_valid) ? ptr : req1_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (transfer) begin
            ptr <= ~grant;
        end
    end
`else
    always_comb begin
        grant = req1_valid && !req0_valid;
    end
`endif

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        transfer   = 1'b0;
        rsp_fire   = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = req0_valid && !grant;
                req1_ready = req1_valid && grant;
                transfer   = req0_valid || req1_valid;
                if (transfer) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                rsp_fire   = owner ? rsp1_ready : rsp0_ready;
                if (rsp_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            opc_q    <= '0;
            owner    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state <= state_next;
            if (transfer) begin
                op1_q <= grant ? req1_operand1  : req0_operand1;
                op2_q <= grant ? req1_operand2  : req0_operand2;
                opc_q <= grant ? req1_operation : req0_operation;
                owner <= grant;
            end
            if (state == EXEC) begin
                result_q <= alu_result;
            end
        end
    end

    // The ALU only ever sees registered values, so requester inputs never reach it combinationally.
    assign alu_operand1  = op1_q;
    assign alu_operand2  = op2_q;
    assign alu_operation = opc_q;
    assign rsp_result    = result_q;
    assign busy          = (state != IDLE);

endmodule
